// File: rtl/affine_pkg.sv
// Shared definitions for the affine subblock motion-vector sequencer.
package affine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Affine model precision: deltas and accumulations carry 7 extra fraction bits.
    localparam int AFF_SHIFT = 7;

    // Clamp a wide signed value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned     w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/affine_mv_calc.sv
// Combinational affine MV evaluation at one subblock centre, with rounding,
// saturation and the integer/fraction split.
module affine_mv_calc
    import affine_pkg::*;
#(
    parameter int MV_W      = 16,
    parameter int FRAC_BITS = 4,
    parameter int SB_LOG2   = 2,
    parameter int DLT_W     = MV_W + 6,
    parameter int OFF_W     = 7
) (
    input  logic signed [MV_W-1:0]           i_mv0_x,
    input  logic signed [MV_W-1:0]           i_mv0_y,
    input  logic signed [DLT_W-1:0]          i_dh_x,
    input  logic signed [DLT_W-1:0]          i_dh_y,
    input  logic signed [DLT_W-1:0]          i_dv_x,
    input  logic signed [DLT_W-1:0]          i_dv_y,
    input  logic        [OFF_W-1:0]          i_sx,
    input  logic        [OFF_W-1:0]          i_sy,
    output logic signed [MV_W-FRAC_BITS-1:0] o_int_x,
    output logic signed [MV_W-FRAC_BITS-1:0] o_int_y,
    output logic        [FRAC_BITS-1:0]      o_frac_x,
    output logic        [FRAC_BITS-1:0]      o_frac_y
);

    // Wide enough that no term of the affine sum can overflow.
    localparam int ACC_W = MV_W + 20;
    localparam logic signed [OFF_W+1:0] HALF = (OFF_W + 2)'(1 << (SB_LOG2 - 1));

    logic signed [OFF_W+1:0] w_xc;
    logic signed [OFF_W+1:0] w_yc;
    logic signed [MV_W-1:0]  w_mv_x;
    logic signed [MV_W-1:0]  w_mv_y;

    // One MV component: (mv0<<7 + dH*xc + dV*yc + 64) >>> 7, then clamp.
    function automatic logic signed [MV_W-1:0] comp(input logic signed [MV_W-1:0]  mv0,
                                                    input logic signed [DLT_W-1:0] dh,
                                                    input logic signed [DLT_W-1:0] dv,
                                                    input logic signed [OFF_W+1:0] xc,
                                                    input logic signed [OFF_W+1:0] yc);
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] shr;
        acc = (ACC_W'(mv0) <<< AFF_SHIFT)
            + ACC_W'(dh) * ACC_W'(xc)
            + ACC_W'(dv) * ACC_W'(yc)
            + ACC_W'(1 <<< (AFF_SHIFT - 1));
        shr = acc >>> AFF_SHIFT;
        return MV_W'(sat_signed(64'(shr), MV_W));
    endfunction

    // Subblock centre: offset plus half a subblock.
    assign w_xc = $signed({2'b00, i_sx}) + HALF;
    assign w_yc = $signed({2'b00, i_sy}) + HALF;

    assign w_mv_x = comp(i_mv0_x, i_dh_x, i_dv_x, w_xc, w_yc);
    assign w_mv_y = comp(i_mv0_y, i_dh_y, i_dv_y, w_xc, w_yc);

    // Floor integer part is the top bits; fraction is the low bits, unsigned.
    assign o_int_x  = w_mv_x[MV_W-1:FRAC_BITS];
    assign o_int_y  = w_mv_y[MV_W-1:FRAC_BITS];
    assign o_frac_x = w_mv_x[FRAC_BITS-1:0];
    assign o_frac_y = w_mv_y[FRAC_BITS-1:0];

endmodule

// File: rtl/affine_mv_seq.sv
// Affine subblock MV sequencer: latches a block's control-point MVs, then
// emits one MV per subblock in raster order over a valid/ready handshake.
module affine_mv_seq
    import affine_pkg::*;
#(
    parameter int BLK_W_LOG2 = 4,
    parameter int BLK_H_LOG2 = 4,
    parameter int SB_LOG2    = 2,
    parameter int MV_W       = 16,
    parameter int FRAC_BITS  = 4,
    parameter int COORD_W    = 8
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             START,
    input  logic                             MODE,
    input  logic        [COORD_W-1:0]        COORD_X,
    input  logic        [COORD_W-1:0]        COORD_Y,
    input  logic        [2*MV_W-1:0]         CPMV_0,
    input  logic        [2*MV_W-1:0]         CPMV_1,
    input  logic        [2*MV_W-1:0]         CPMV_2,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic        [COORD_W-1:0]        OUT_SB_X,
    output logic        [COORD_W-1:0]        OUT_SB_Y,
    output logic signed [MV_W-FRAC_BITS-1:0] OUT_MV_X_INT,
    output logic signed [MV_W-FRAC_BITS-1:0] OUT_MV_Y_INT,
    output logic        [FRAC_BITS-1:0]      OUT_MV_X_FRAC,
    output logic        [FRAC_BITS-1:0]      OUT_MV_Y_FRAC,
    output logic                             OUT_LAST,
    output logic                             BUSY,
    output logic                             DONE
);

    localparam int OFF_W = 7;
    localparam int DLT_W = MV_W + 6;
    localparam int SH_H  = AFF_SHIFT - BLK_W_LOG2;
    localparam int SH_V  = AFF_SHIFT - BLK_H_LOG2;
    localparam int NX_W  = (BLK_W_LOG2 > SB_LOG2) ? (BLK_W_LOG2 - SB_LOG2) : 1;
    localparam int NY_W  = (BLK_H_LOG2 > SB_LOG2) ? (BLK_H_LOG2 - SB_LOG2) : 1;
    localparam logic [NX_W-1:0] X_MAX = NX_W'((1 << (BLK_W_LOG2 - SB_LOG2)) - 1);
    localparam logic [NY_W-1:0] Y_MAX = NY_W'((1 << (BLK_H_LOG2 - SB_LOG2)) - 1);

    state_t r_state, w_next;

    logic                             r_mode;
    logic        [COORD_W-1:0]        r_org_x, r_org_y;
    logic signed [MV_W-1:0]           r_mv0_x, r_mv0_y, r_mv1_x, r_mv1_y, r_mv2_x, r_mv2_y;
    logic signed [DLT_W-1:0]          r_dh_x, r_dh_y, r_dv_x, r_dv_y;
    logic        [NX_W-1:0]           r_cnt_x;
    logic        [NY_W-1:0]           r_cnt_y;
    logic        [COORD_W-1:0]        r_sb_x, r_sb_y;
    logic signed [MV_W-FRAC_BITS-1:0] r_int_x, r_int_y;
    logic        [FRAC_BITS-1:0]      r_frac_x, r_frac_y;
    logic                             r_last;

    logic signed [DLT_W-1:0]          w_dh_x, w_dh_y, w_dv_x, w_dv_y;
    logic        [OFF_W-1:0]          w_sx, w_sy;
    logic signed [MV_W-FRAC_BITS-1:0] w_int_x, w_int_y;
    logic        [FRAC_BITS-1:0]      w_frac_x, w_frac_y;
    logic                             w_last;

    // Horizontal deltas always from CPMV1; vertical ones from CPMV2 or the
    // 4-parameter rotation/zoom model.
    assign w_dh_x = (DLT_W'(r_mv1_x) - DLT_W'(r_mv0_x)) <<< SH_H;
    assign w_dh_y = (DLT_W'(r_mv1_y) - DLT_W'(r_mv0_y)) <<< SH_H;
    assign w_dv_x = r_mode ? ((DLT_W'(r_mv2_x) - DLT_W'(r_mv0_x)) <<< SH_V) : -w_dh_y;
    assign w_dv_y = r_mode ? ((DLT_W'(r_mv2_y) - DLT_W'(r_mv0_y)) <<< SH_V) : w_dh_x;

    assign w_sx   = OFF_W'(r_cnt_x) << SB_LOG2;
    assign w_sy   = OFF_W'(r_cnt_y) << SB_LOG2;
    assign w_last = (r_cnt_x == X_MAX) && (r_cnt_y == Y_MAX);

    affine_mv_calc #(
        .MV_W      (MV_W),
        .FRAC_BITS (FRAC_BITS),
        .SB_LOG2   (SB_LOG2),
        .DLT_W     (DLT_W),
        .OFF_W     (OFF_W)
    ) u_calc (
        .i_mv0_x  (r_mv0_x),
        .i_mv0_y  (r_mv0_y),
        .i_dh_x   (r_dh_x),
        .i_dh_y   (r_dh_y),
        .i_dv_x   (r_dv_x),
        .i_dv_y   (r_dv_y),
        .i_sx     (w_sx),
        .i_sy     (w_sy),
        .o_int_x  (w_int_x),
        .o_int_y  (w_int_y),
        .o_frac_x (w_frac_x),
        .o_frac_y (w_frac_y)
    );

    // State register; reset forces IDLE at any point in a block.
    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (START) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_CALC;
            ST_CALC: w_next = ST_EMIT;
            ST_EMIT: if (OUT_READY) w_next = w_last ? ST_FIN : ST_CALC;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Latched block inputs, deltas, subblock counters and output payload.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_mode   <= 1'b0;
            r_org_x  <= '0;
            r_org_y  <= '0;
            r_mv0_x  <= '0;
            r_mv0_y  <= '0;
            r_mv1_x  <= '0;
            r_mv1_y  <= '0;
            r_mv2_x  <= '0;
            r_mv2_y  <= '0;
            r_dh_x   <= '0;
            r_dh_y   <= '0;
            r_dv_x   <= '0;
            r_dv_y   <= '0;
            r_cnt_x  <= '0;
            r_cnt_y  <= '0;
            r_sb_x   <= '0;
            r_sb_y   <= '0;
            r_int_x  <= '0;
            r_int_y  <= '0;
            r_frac_x <= '0;
            r_frac_y <= '0;
            r_last   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_mode  <= MODE;
                        r_org_x <= COORD_X;
                        r_org_y <= COORD_Y;
                        r_mv0_x <= CPMV_0[MV_W-1:0];
                        r_mv0_y <= CPMV_0[2*MV_W-1:MV_W];
                        r_mv1_x <= CPMV_1[MV_W-1:0];
                        r_mv1_y <= CPMV_1[2*MV_W-1:MV_W];
                        r_mv2_x <= CPMV_2[MV_W-1:0];
                        r_mv2_y <= CPMV_2[2*MV_W-1:MV_W];
                    end
                end
                ST_LOAD: begin
                    r_dh_x  <= w_dh_x;
                    r_dh_y  <= w_dh_y;
                    r_dv_x  <= w_dv_x;
                    r_dv_y  <= w_dv_y;
                    r_cnt_x <= '0;
                    r_cnt_y <= '0;
                end
                ST_CALC: begin
                    r_sb_x   <= r_org_x + COORD_W'(w_sx);
                    r_sb_y   <= r_org_y + COORD_W'(w_sy);
                    r_int_x  <= w_int_x;
                    r_int_y  <= w_int_y;
                    r_frac_x <= w_frac_x;
                    r_frac_y <= w_frac_y;
                    r_last   <= w_last;
                end
                ST_EMIT: begin
                    if (OUT_READY && !w_last) begin
                        if (r_cnt_x == X_MAX) begin
                            r_cnt_x <= '0;
                            r_cnt_y <= r_cnt_y + 1'b1;
                        end else begin
                            r_cnt_x <= r_cnt_x + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign OUT_VALID     = (r_state == ST_EMIT);
    assign BUSY          = (r_state != ST_IDLE);
    assign DONE          = (r_state == ST_FIN);
    assign OUT_SB_X      = r_sb_x;
    assign OUT_SB_Y      = r_sb_y;
    assign OUT_MV_X_INT  = r_int_x;
    assign OUT_MV_Y_INT  = r_int_y;
    assign OUT_MV_X_FRAC = r_frac_x;
    assign OUT_MV_Y_FRAC = r_frac_y;
    assign OUT_LAST      = r_last;

endmodule

// File: doc/affine_mv_seq.md
AFFINE_MV_SEQ -- requirements
Module: affine_mv_seq

Interface
REQ-001 SHALL have parameter BLK_W_LOG2, default 4, meaning log2 block width in samples (legal 3..7).
REQ-002 SHALL have parameter BLK_H_LOG2, default 4, meaning log2 block height in samples (legal 3..7).
REQ-003 SHALL have parameter SB_LOG2, default 2, meaning log2 subblock size (legal 2..3, not above either BLK log2).
REQ-004 SHALL have parameter MV_W, default 16, meaning signed width of one MV component.
REQ-005 SHALL have parameter FRAC_BITS, default 4, meaning MV fractional bits (1/16 pel).
REQ-006 SHALL have parameter COORD_W, default 8, meaning coordinate width.
REQ-007 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port RESET_N, input, 1, synchronous active-low reset.
REQ-009 SHALL have port START, input, 1, request to process one block; sampled only in IDLE.
REQ-010 SHALL have port MODE, input, 1, affine model: 0 = 4-parameter, 1 = 6-parameter.
REQ-011 SHALL have ports COORD_X and COORD_Y, input, COORD_W each, block origin.
REQ-012 SHALL have ports CPMV_0, CPMV_1 and CPMV_2, input, 2*MV_W each, packed {y,x} signed; CPMV_2 is used only when MODE=1.
REQ-013 SHALL have port OUT_VALID, output, 1, subblock result valid.
REQ-014 SHALL have port OUT_READY, input, 1, consumer accepts.
REQ-015 SHALL have ports OUT_SB_X and OUT_SB_Y, output, COORD_W each, absolute subblock origin, modulo 2^COORD_W.
REQ-016 SHALL have ports OUT_MV_X_INT and OUT_MV_Y_INT, output, MV_W-FRAC_BITS each, signed integer MV (floor).
REQ-017 SHALL have ports OUT_MV_X_FRAC and OUT_MV_Y_FRAC, output, FRAC_BITS each, unsigned fractional MV.
REQ-018 SHALL have port OUT_LAST, output, 1, high with the final subblock of the block.
REQ-019 SHALL have ports BUSY, output, 1, high outside IDLE, and DONE, output, 1, one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM IDLE->LOAD->CALC->EMIT->(CALC | FIN)->IDLE.
REQ-021 In IDLE with START=1, SHALL go to LOAD and latch MODE, the coordinates and the CPMVs; inputs are then ignored until IDLE.
REQ-022 LOAD SHALL compute the deltas from the latched values: dHx=(mv1x-mv0x)<<<(7-BLK_W_LOG2) and dHy=(mv1y-mv0y)<<<(7-BLK_W_LOG2).
REQ-023 In LOAD, when MODE=0, SHALL set dVx=-dHy and dVy=dHx.
REQ-024 In LOAD, when MODE=1, SHALL set dVx=(mv2x-mv0x)<<<(7-BLK_H_LOG2) and dVy=(mv2y-mv0y)<<<(7-BLK_H_LOG2).
REQ-025 CALC SHALL use centre xc=sx+2^(SB_LOG2-1) and yc=sy+2^(SB_LOG2-1), where (sx,sy) is the subblock offset inside the block.
REQ-026 CALC SHALL form mv=((mv0<<<7)+dH*xc+dV*yc+64)>>>7 per component, arithmetic shift, with no intermediate overflow (ACC_W >= MV_W+18).
REQ-027 CALC SHALL saturate each component to the signed MV_W range.
REQ-028 CALC SHALL register INT=mv>>>FRAC_BITS and FRAC=mv[FRAC_BITS-1:0] into the output registers.
REQ-029 Subblocks SHALL be visited in raster order, x inner, for (2^BLK_W_LOG2/2^SB_LOG2)*(2^BLK_H_LOG2/2^SB_LOG2) results.
REQ-030 OUT_VALID SHALL be high exactly in EMIT; the payload SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 A handshake (EMIT and OUT_READY=1) on a non-last subblock SHALL advance the counters and go to CALC, giving a one-cycle bubble between results.
REQ-032 A handshake on the last subblock SHALL go to FIN.
REQ-033 FIN SHALL assert DONE for one cycle, then go to IDLE; START in FIN is ignored.
REQ-034 Latency SHALL be START sampled at cycle t -> OUT_VALID at cycle t+3.
REQ-035 Counter wrap SHALL return the x counter to 0 and increment y; the final y wrap coincides with OUT_LAST.
REQ-036 OUT_READY high outside EMIT SHALL have no effect.

Reset
REQ-037 RESET_N=0 at a clock edge SHALL force IDLE, including mid-block, and discard any pending result.
REQ-038 On reset SHALL clear counters and latched inputs to 0.
REQ-039 On reset SHALL drive every output to 0: OUT_VALID, OUT_LAST, BUSY, DONE, OUT_SB_X/Y and all MV outputs.
REQ-040 START SHALL be honoured on the first edge after RESET_N returns high.

Structure
REQ-041 Package affine_pkg SHALL hold the state encoding, constant AFF_SHIFT=7 and a saturation function.
REQ-042 The combinational MV arithmetic of REQ-025..028 SHALL be one sub-module, affine_mv_calc; FSM, counters and registers stay in affine_mv_seq.

Verification
REQ-043 Default parameters, MODE=0, CPMV_0=CPMV_1=(x16,y0), READY=1 -> 16 results, each MV_X_INT=1, MV_X_FRAC=0, MV_Y=0; OUT_LAST only on #16; DONE one cycle later.
REQ-044 MODE=0, CPMV_0=(0,0), CPMV_1=(64,0), origin (32,48) -> first result SB (32,48), MV X/Y INT=0, FRAC=8; last result SB (44,60), MV X/Y INT=3, FRAC=8.
REQ-045 MODE=0, CPMV_0=CPMV_1=(-20,0) -> every MV_X_INT=-2 and MV_X_FRAC=12.
REQ-046 MODE=1, CPMV_0=CPMV_1=(0,0), CPMV_2=(0,32) -> row 0 MV_Y_INT=0, FRAC=4; row 3 MV_Y_INT=1, FRAC=12; MV_X=0 throughout.
REQ-047 OUT_READY held low 5 cycles on result #3 -> payload unchanged during the stall, no result lost or duplicated; a START pulse while BUSY is ignored.
REQ-048 RESET_N low after result #5 -> next cycle all outputs 0 and state IDLE; a new START yields result #1 of the new block at t+3.
